// File: rtl/orv64_typedef_pkg.sv
// Shared orv64 types for the instruction trace buffer: entry/address types, controller states
// and buffer depth.
package orv64_typedef_pkg;

  localparam int unsigned ORV64_ITB_ADDR_W = 6;
  localparam int unsigned ORV64_ITB_DATA_W = 64;

  typedef logic [ORV64_ITB_ADDR_W-1:0] orv64_itb_addr_t;
  typedef logic [ORV64_ITB_DATA_W-1:0] orv64_itb_data_t;

  typedef enum logic [2:0] {
    ITB_OFF    = 3'd0,
    ITB_WAKE   = 3'd1,
    ITB_IDLE   = 3'd2,
    ITB_RECORD = 3'd3,
    ITB_POST   = 3'd4,
    ITB_FROZEN = 3'd5
  } orv64_itb_ctrl_state_e;

  localparam int unsigned ORV64_ITB_DEPTH = 2**$bits(orv64_itb_addr_t);

  // Circular-buffer pointer advance; wraps naturally at DEPTH.
  function automatic orv64_itb_addr_t orv64_itb_ptr_inc(input orv64_itb_addr_t ptr);
    return ptr + orv64_itb_addr_t'(1);
  endfunction

endpackage

// File: rtl/orv64_itb_ctrl.sv
// ITB RAM controller: power-up sequencing, circular trace capture, freeze and debug-port arbitration.
// ORV64_ITB_TRIGGER_EN adds trigger-driven post-capture (POST state).
module orv64_itb_ctrl
  import orv64_typedef_pkg::*;
#(
  parameter int unsigned PWR_UP_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_pwr_on,
  input  logic            cfg_itb_en,
  input  logic            cfg_itb_stop_full,
  input  orv64_itb_addr_t cfg_itb_post_trig,
  input  logic            trace_valid,
  input  orv64_itb_data_t trace_data,
  input  logic            trace_trigger,
  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic            dbg_req_rw,
  input  orv64_itb_addr_t dbg_req_addr,
  input  orv64_itb_data_t dbg_req_wdata,
  output logic            dbg_resp_valid,
  input  logic            dbg_resp_ready,
  output orv64_itb_data_t dbg_resp_rdata,
  output logic            itb_en,
  output orv64_itb_data_t itb_data,
  output orv64_itb_addr_t itb_addr,
  output logic            itb_dbg_en,
  output logic            itb_dbg_rw,
  output orv64_itb_data_t itb_dbg_din,
  output orv64_itb_addr_t itb_dbg_addr,
  input  orv64_itb_data_t itb_dbg_dout,
  output orv64_itb_addr_t itb_wr_ptr,
  output logic            itb_wrapped,
  output logic            itb_frozen
);

  localparam int unsigned WAKE_W = (PWR_UP_CYCLES > 1) ? $clog2(PWR_UP_CYCLES) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(PWR_UP_CYCLES - 1);
  localparam orv64_itb_addr_t PTR_LAST = orv64_itb_addr_t'(ORV64_ITB_DEPTH - 1);

  orv64_itb_ctrl_state_e r_state, w_state_nxt;
  logic [WAKE_W-1:0]     r_wake_cnt, w_wake_cnt_nxt;
  orv64_itb_addr_t       r_wr_ptr, w_wr_ptr_nxt;
  logic                  r_wrapped, w_wrapped_nxt;
  logic                  r_resp_valid, r_resp_rd;
  logic                  w_trace_wr, w_last_wr, w_dbg_fire;

`ifdef ORV64_ITB_TRIGGER_EN
  orv64_itb_addr_t r_post_cnt, w_post_cnt_nxt;
`else
  logic w_unused;
  assign w_unused = ^{trace_trigger, cfg_itb_post_trig};
`endif

  assign w_last_wr = trace_valid && (r_wr_ptr == PTR_LAST);

  // Next-state, pointer and capture decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_wake_cnt_nxt = r_wake_cnt;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_wrapped_nxt  = r_wrapped;
    w_trace_wr     = 1'b0;
`ifdef ORV64_ITB_TRIGGER_EN
    w_post_cnt_nxt = r_post_cnt;
`endif
    if (!cfg_pwr_on) begin
      w_state_nxt = ITB_OFF;
    end else begin
      case (r_state)
        ITB_OFF: begin
          w_state_nxt    = ITB_WAKE;
          w_wake_cnt_nxt = WAKE_LOAD;
        end
        ITB_WAKE: begin
          if (r_wake_cnt == '0) w_state_nxt = ITB_IDLE;
          else                  w_wake_cnt_nxt = r_wake_cnt - WAKE_W'(1);
        end
        ITB_IDLE: begin
          if (cfg_itb_en) begin
            w_state_nxt   = ITB_RECORD;
            w_wr_ptr_nxt  = '0;
            w_wrapped_nxt = 1'b0;
          end
        end
        ITB_RECORD, ITB_POST: begin
          if (!cfg_itb_en) begin
            w_state_nxt = ITB_FROZEN;
          end else begin
            w_trace_wr = trace_valid;
            if (trace_valid) w_wr_ptr_nxt = orv64_itb_ptr_inc(r_wr_ptr);
            if (w_last_wr) begin
              w_wrapped_nxt = 1'b1;
              if (cfg_itb_stop_full) w_state_nxt = ITB_FROZEN;
            end
`ifdef ORV64_ITB_TRIGGER_EN
            // Trigger-cycle entry is not counted; the write seen at count 1 is the last.
            if (r_state == ITB_POST) begin
              if (trace_valid) begin
                w_post_cnt_nxt = r_post_cnt - orv64_itb_addr_t'(1);
                if (r_post_cnt == orv64_itb_addr_t'(1)) w_state_nxt = ITB_FROZEN;
              end
            end else if (trace_trigger && !(w_last_wr && cfg_itb_stop_full)) begin
              if (cfg_itb_post_trig == '0) begin
                w_state_nxt = ITB_FROZEN;
              end else begin
                w_state_nxt    = ITB_POST;
                w_post_cnt_nxt = cfg_itb_post_trig;
              end
            end
`endif
          end
        end
        ITB_FROZEN: begin
          if (!cfg_itb_en) w_state_nxt = ITB_IDLE;
        end
        default: w_state_nxt = ITB_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ITB_OFF;
      r_wake_cnt <= '0;
      r_wr_ptr   <= '0;
      r_wrapped  <= 1'b0;
`ifdef ORV64_ITB_TRIGGER_EN
      r_post_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_wrapped  <= w_wrapped_nxt;
`ifdef ORV64_ITB_TRIGGER_EN
      r_post_cnt <= w_post_cnt_nxt;
`endif
    end
  end

  // Debug port only owns the RAM while capture is stopped and no response is stalled.
  assign dbg_req_ready = ((r_state == ITB_IDLE) || (r_state == ITB_FROZEN)) &&
                         !(r_resp_valid && !dbg_resp_ready);
  assign w_dbg_fire    = dbg_req_valid && dbg_req_ready;

  always_ff @(posedge clk) begin
    if (rst || !cfg_pwr_on) begin
      r_resp_valid <= 1'b0;
      r_resp_rd    <= 1'b0;
    end else if (w_dbg_fire) begin
      r_resp_valid <= 1'b1;
      r_resp_rd    <= !dbg_req_rw;
    end else if (dbg_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign dbg_resp_valid = r_resp_valid;
  assign dbg_resp_rdata = (r_resp_valid && r_resp_rd) ? itb_dbg_dout : '0;

  assign itb_en       = w_trace_wr;
  assign itb_addr     = r_wr_ptr;
  assign itb_data     = w_trace_wr ? trace_data : '0;
  assign itb_dbg_en   = w_dbg_fire;
  assign itb_dbg_rw   = w_dbg_fire && dbg_req_rw;
  assign itb_dbg_addr = w_dbg_fire ? dbg_req_addr : '0;
  assign itb_dbg_din  = (w_dbg_fire && dbg_req_rw) ? dbg_req_wdata : '0;

  assign itb_wr_ptr  = r_wr_ptr;
  assign itb_wrapped = r_wrapped;
  assign itb_frozen  = (r_state == ITB_FROZEN);

  a_trace_dbg_excl: assert property (@(posedge clk) disable iff (rst) !(itb_en && itb_dbg_en));

endmodule

// File: tb/tb_orv64_itb_ctrl.sv
// Randomized bench for orv64_itb_ctrl with a RAM model and a queue-based capture reference.
module tb_orv64_itb_ctrl;
  import orv64_typedef_pkg::*;

  localparam int unsigned PWR_UP = 4;
  localparam int unsigned DEPTH  = ORV64_ITB_DEPTH;
`ifdef ORV64_ITB_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, cfg_pwr_on, cfg_itb_en, cfg_itb_stop_full;
  orv64_itb_addr_t cfg_itb_post_trig;
  logic trace_valid, trace_trigger;
  orv64_itb_data_t trace_data;
  logic dbg_req_valid, dbg_req_ready, dbg_req_rw, dbg_resp_valid, dbg_resp_ready;
  orv64_itb_addr_t dbg_req_addr;
  orv64_itb_data_t dbg_req_wdata, dbg_resp_rdata;
  logic itb_en, itb_dbg_en, itb_dbg_rw, itb_wrapped, itb_frozen;
  orv64_itb_data_t itb_data, itb_dbg_din, itb_dbg_dout;
  orv64_itb_addr_t itb_addr, itb_dbg_addr, itb_wr_ptr;

  int n_chk = 0;
  int n_fail = 0;

  orv64_itb_ctrl #(.PWR_UP_CYCLES(PWR_UP)) u_dut (
    .clk(clk), .rst(rst), .cfg_pwr_on(cfg_pwr_on), .cfg_itb_en(cfg_itb_en),
    .cfg_itb_stop_full(cfg_itb_stop_full), .cfg_itb_post_trig(cfg_itb_post_trig),
    .trace_valid(trace_valid), .trace_data(trace_data), .trace_trigger(trace_trigger),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_rw(dbg_req_rw),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_resp_valid(dbg_resp_valid), .dbg_resp_ready(dbg_resp_ready),
    .dbg_resp_rdata(dbg_resp_rdata), .itb_en(itb_en), .itb_data(itb_data), .itb_addr(itb_addr),
    .itb_dbg_en(itb_dbg_en), .itb_dbg_rw(itb_dbg_rw), .itb_dbg_din(itb_dbg_din),
    .itb_dbg_addr(itb_dbg_addr), .itb_dbg_dout(itb_dbg_dout), .itb_wr_ptr(itb_wr_ptr),
    .itb_wrapped(itb_wrapped), .itb_frozen(itb_frozen)
  );

  always #5 clk = ~clk;

  // RAM model plus a log of every trace write the DUT issues.
  orv64_itb_data_t ram [DEPTH];
  orv64_itb_addr_t log_addr[$];
  orv64_itb_data_t log_data[$];
  always @(posedge clk) begin
    if (itb_en) begin
      ram[itb_addr] = itb_data;
      log_addr.push_back(itb_addr);
      log_data.push_back(itb_data);
    end
    if (itb_dbg_en) begin
      if (itb_dbg_rw) ram[itb_dbg_addr] = itb_dbg_din;
      else            itb_dbg_dout <= ram[itb_dbg_addr];
    end
  end

  // Reference: what the buffer should hold, tracked from the stimulus alone.
  orv64_itb_data_t exp_mem [DEPTH];
  orv64_itb_addr_t exp_addr[$];
  orv64_itb_data_t exp_data[$];
  bit m_rec, m_post, m_wrapped;
  int m_ptr, m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rec = 1'b1; m_post = 1'b0; m_wrapped = 1'b0; m_ptr = 0; m_cnt = 0;
    exp_addr.delete(); exp_data.delete(); log_addr.delete(); log_data.delete();
  endtask

  // Account for the trace inputs currently driven, before the clock edge that samples them.
  task automatic model_cycle();
    bit was_rec, was_post;
    if (!cfg_itb_en) m_rec = 1'b0;
    was_rec = m_rec;
    was_post = m_post;
    if (was_rec && trace_valid) begin
      exp_addr.push_back(orv64_itb_addr_t'(m_ptr));
      exp_data.push_back(trace_data);
      exp_mem[m_ptr] = trace_data;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_ptr == 0) begin
        m_wrapped = 1'b1;
        if (cfg_itb_stop_full) m_rec = 1'b0;
      end
      if (was_post) begin
        if (m_cnt == 1) m_rec = 1'b0;
        m_cnt = m_cnt - 1;
      end
    end
    if (TRIG_EN && was_rec && m_rec && !was_post && trace_trigger) begin
      if (cfg_itb_post_trig == 0) m_rec = 1'b0;
      else begin m_post = 1'b1; m_cnt = int'(cfg_itb_post_trig); end
    end
  endtask

  task automatic rec_run(input int n_valid, input int trig_idx);
    int seen = 0;
    int cyc = 0;
    while (seen < n_valid && cyc < 2000) begin
      trace_valid   = ($urandom_range(3) != 0);
      trace_data    = {$urandom, $urandom};
      trace_trigger = trace_valid && (seen == trig_idx);
      model_cycle();
      if (trace_valid) seen++;
      cyc++;
      tick();
    end
    trace_valid = 1'b0;
    trace_trigger = 1'b0;
  endtask

  task automatic cmp_logs(input string tag);
    chk({tag, "_count"}, 64'(log_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      chk($sformatf("%s_addr[%0d]", tag, i), 64'(log_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("%s_data[%0d]", tag, i), log_data[i], exp_data[i]);
    end
    log_addr.delete(); log_data.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic rearm();
    cfg_itb_en = 1'b0;
    tick();
    tick();
    cfg_itb_en = 1'b1;
    tick();
    model_reset();
    chk("rearm_wr_ptr", 64'(itb_wr_ptr), 64'd0);
    chk("rearm_wrapped", 64'(itb_wrapped), 64'd0);
  endtask

  task automatic dbg_txn(input bit rw, input orv64_itb_addr_t a, input orv64_itb_data_t wd,
                         input int hold);
    int w = 0;
    orv64_itb_data_t exp_rd;
    dbg_req_valid = 1'b1; dbg_req_rw = rw; dbg_req_addr = a; dbg_req_wdata = wd;
    dbg_resp_ready = (hold == 0);
    #1;
    while (!dbg_req_ready && w < 20) begin tick(); #1; w++; end
    chk("dbg_req_ready", 64'(dbg_req_ready), 64'd1);
    exp_rd = rw ? '0 : exp_mem[a];
    if (rw) exp_mem[a] = wd;
    tick();
    dbg_req_valid = 1'b0;
    chk("dbg_resp_valid", 64'(dbg_resp_valid), 64'd1);
    chk("dbg_resp_rdata", dbg_resp_rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("dbg_hold_valid", 64'(dbg_resp_valid), 64'd1);
      chk("dbg_hold_rdata", dbg_resp_rdata, exp_rd);
    end
    dbg_resp_ready = 1'b1;
    tick();
    chk("dbg_resp_done", 64'(dbg_resp_valid), 64'd0);
  endtask

  initial begin
    int n;
    orv64_itb_addr_t a;
    orv64_itb_data_t exp_rd;
    rst = 1'b1; cfg_pwr_on = 1'b0; cfg_itb_en = 1'b0; cfg_itb_stop_full = 1'b0;
    cfg_itb_post_trig = '0; trace_valid = 1'b0; trace_trigger = 1'b0; trace_data = '0;
    dbg_req_valid = 1'b0; dbg_req_rw = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
    dbg_resp_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_itb_en", 64'(itb_en), 64'd0);
    chk("rst_dbg_en", 64'(itb_dbg_en), 64'd0);
    chk("rst_req_ready", 64'(dbg_req_ready), 64'd0);
    chk("rst_resp_valid", 64'(dbg_resp_valid), 64'd0);
    chk("rst_wr_ptr", 64'(itb_wr_ptr), 64'd0);
    chk("rst_wrapped", 64'(itb_wrapped), 64'd0);
    chk("rst_frozen", 64'(itb_frozen), 64'd0);

    // Power-up: one edge leaves OFF, PWR_UP wake cycles, one IDLE cycle, then RECORD.
    rst = 1'b0; cfg_pwr_on = 1'b1; cfg_itb_en = 1'b1;
    trace_valid = 1'b1; trace_data = {$urandom, $urandom};
    n = 0;
    do begin tick(); n++; end while (!itb_en && n < 20);
    chk("pwrup_latency", 64'(n), 64'(PWR_UP + 2));
    chk("pwrup_first_addr", 64'(itb_addr), 64'd0);
    model_reset();
    model_cycle();
    tick();

    // Wrap mode: 64 entries wrap the pointer, 6 more land at 0..5.
    rec_run(63, -1);
    chk("wrap64_wrapped", 64'(itb_wrapped), 64'(m_wrapped));
    chk("wrap64_wr_ptr", 64'(itb_wr_ptr), 64'(m_ptr));
    rec_run(6, -1);
    chk("wrap70_wr_ptr", 64'(itb_wr_ptr), 64'(m_ptr));
    chk("wrap70_frozen", 64'(itb_frozen), 64'd0);
    if (log_addr.size() > 64) chk("entry65_addr", 64'(log_addr[64]), 64'd0);
    else chk("entry65_present", 64'(log_addr.size()), 64'd70);
    cmp_logs("wrap");

    // Stop-full: freezes after address 63; further valids dropped.
    cfg_itb_stop_full = 1'b1;
    rearm();
    rec_run(65, -1);
    chk("full_frozen", 64'(itb_frozen), 64'(!m_rec));
    chk("full_wr_ptr", 64'(itb_wr_ptr), 64'(m_ptr));
    chk("full_wrapped", 64'(itb_wrapped), 64'(m_wrapped));
    cmp_logs("full");
    dbg_txn(1'b0, '0, '0, 0);

    // Frozen debug access with a stalled read response.
    dbg_txn(1'b1, orv64_itb_addr_t'(3), 64'hA5, 0);
    dbg_txn(1'b0, orv64_itb_addr_t'(3), '0, 3);

    // Debug requests stay blocked while recording; freeze releases them.
    cfg_itb_stop_full = 1'b0;
    rearm();
    a = orv64_itb_addr_t'($urandom_range(DEPTH - 1));
    dbg_req_valid = 1'b1; dbg_req_rw = 1'b0; dbg_req_addr = a;
    for (int i = 0; i < 12; i++) begin
      trace_valid = ($urandom_range(1) != 0);
      trace_data = {$urandom, $urandom};
      model_cycle();
      #1;
      chk("rec_req_ready", 64'(dbg_req_ready), 64'd0);
      chk("rec_dbg_en", 64'(itb_dbg_en), 64'd0);
      tick();
    end
    cfg_itb_en = 1'b0; trace_valid = 1'b1; trace_data = {$urandom, $urandom};
    model_cycle();
    tick();
    trace_valid = 1'b0;
    chk("stop_frozen", 64'(itb_frozen), 64'd1);
    #1;
    chk("stop_req_ready", 64'(dbg_req_ready), 64'd1);
    exp_rd = exp_mem[a];
    tick();
    dbg_req_valid = 1'b0;
    chk("stop_resp_valid", 64'(dbg_resp_valid), 64'd1);
    chk("stop_resp_rdata", dbg_resp_rdata, exp_rd);
    cmp_logs("stop");
    tick();

    // Random debug traffic in IDLE against the known buffer contents.
    for (int i = 0; i < 16; i++)
      dbg_txn(1'($urandom_range(1)), orv64_itb_addr_t'($urandom_range(DEPTH - 1)),
              {$urandom, $urandom}, $urandom_range(2));

    // Back-to-back reads, one per cycle.
    dbg_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dbg_req_valid = 1'b1; dbg_req_rw = 1'b0; dbg_req_addr = orv64_itb_addr_t'(k);
      #1;
      chk("b2b_ready", 64'(dbg_req_ready), 64'd1);
      tick();
      chk("b2b_valid", 64'(dbg_resp_valid), 64'd1);
      chk("b2b_rdata", dbg_resp_rdata, exp_mem[k]);
    end
    dbg_req_valid = 1'b0;
    tick();

    // Power loss drops a stalled response.
    dbg_resp_ready = 1'b0;
    dbg_req_valid = 1'b1; dbg_req_rw = 1'b0; dbg_req_addr = '0;
    tick();
    dbg_req_valid = 1'b0;
    chk("pwroff_resp_before", 64'(dbg_resp_valid), 64'd1);
    cfg_pwr_on = 1'b0;
    tick();
    chk("pwroff_resp_dropped", 64'(dbg_resp_valid), 64'd0);
    #1;
    chk("pwroff_req_ready", 64'(dbg_req_ready), 64'd0);
    dbg_resp_ready = 1'b1;

    // Trigger with 5 post entries at pointer 10 (ignored in the default build).
    cfg_pwr_on = 1'b1; cfg_itb_en = 1'b1; cfg_itb_post_trig = orv64_itb_addr_t'(5);
    for (int i = 0; i < int'(PWR_UP) + 2; i++) tick();
    model_reset();
    rec_run(20, 10);
    chk("trig_frozen", 64'(itb_frozen), 64'(!m_rec));
    chk("trig_wr_ptr", 64'(itb_wr_ptr), 64'(m_ptr));
    cmp_logs("trig");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
